// File: rtl/dither_gen_tpdf.sv
// Multi-channel TPDF dither source.
// Each lane owns two independent Galois LFSRs (A and B). A request steps every
// LFSR once; on the following edge each lane outputs the difference of the low
// OUT_W-1 bits of A and B, which has a triangular distribution.
//
// Handshake: a request is accepted at a rising edge where en & req & !reseed.
// Exactly one edge later out_valid is high for one cycle and dither_out holds
// the new sample. Without an accepted request, out_valid drops and dither_out
// keeps its last value. A reseed flushes any sample still in flight.
module dither_gen_tpdf #(
  parameter int              BITS     = 32,
  parameter logic [BITS-1:0] MASK     = 32'h46000000,
  parameter int              CHANNELS = 2,
  parameter int              OUT_W    = 8,
  parameter logic [BITS-1:0] SEED_A   = 32'hED02C8A9,
  parameter logic [BITS-1:0] SEED_B   = 32'h1F3A5C77
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      req,
  input  logic                      reseed,
  input  logic [BITS-1:0]           seed_in,
  output logic                      out_valid,
  output logic [CHANNELS*OUT_W-1:0] dither_out,
  output logic                      lockup_err
);

  // One Galois step: shift right, feed the old LSB into the MSB and fold it
  // into the tap positions.
  function automatic logic [BITS-1:0] lfsr_step(input logic [BITS-1:0] s);
    logic [BITS-2:0] t;
    t = s[BITS-1:1] ^ ({(BITS-1){s[0]}} & MASK[BITS-2:0]);
    return {s[0], t};
  endfunction

  // Rotate left by n (n already reduced below BITS): the upper half of the
  // doubled word shifted left is the rotated value.
  function automatic logic [BITS-1:0] rotl(input logic [BITS-1:0] x, input int n);
    logic [2*BITS-1:0] d;
    d = {x, x} << n;
    return d[2*BITS-1:BITS];
  endfunction

  logic [CHANNELS-1:0][BITS-1:0] a_q;
  logic [CHANNELS-1:0][BITS-1:0] b_q;
  logic                          acc_q;
  logic                          step;
  logic                          any_zero;
  logic [BITS-1:0]               seed_a_src;
  logic [BITS-1:0]               seed_b_src;
  logic [CHANNELS*OUT_W-1:0]     diff;

  assign step = en & req & ~reseed;

  // Runtime seeds, substituting the defaults where a source would be all-zero.
  assign seed_a_src = (seed_in == '0) ? SEED_A : seed_in;
  assign seed_b_src = (seed_in == '1) ? SEED_B : ~seed_in;

  // Flag any LFSR sitting in the forbidden all-zero state.
  always_comb begin
    any_zero = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (a_q[c] == '0 || b_q[c] == '0) any_zero = 1'b1;
    end
  end

  // Per-lane unsigned difference; OUT_W bits hold +/-(2^(OUT_W-1)-1) without wrap.
  always_comb begin
    diff = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      diff[c*OUT_W +: OUT_W] = {1'b0, a_q[c][OUT_W-2:0]} - {1'b0, b_q[c][OUT_W-2:0]};
    end
  end

  // LFSR state: reseed beats lockup repair, which beats a normal step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        a_q[c] <= rotl(SEED_A, c % BITS);
        b_q[c] <= rotl(SEED_B, c % BITS);
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (reseed) begin
          a_q[c] <= rotl(seed_a_src, c % BITS);
          b_q[c] <= rotl(seed_b_src, c % BITS);
        end else begin
          if (a_q[c] == '0)  a_q[c] <= rotl(SEED_A, c % BITS);
          else if (step)     a_q[c] <= lfsr_step(a_q[c]);
          if (b_q[c] == '0)  b_q[c] <= rotl(SEED_B, c % BITS);
          else if (step)     b_q[c] <= lfsr_step(b_q[c]);
        end
      end
    end
  end

  // Sticky lockup flag, set whenever a repair load happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       lockup_err <= 1'b0;
    else if (!reseed && any_zero)  lockup_err <= 1'b1;
  end

  // Remember whether the LFSRs were stepped for a request at this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= 1'b0;
    else     acc_q <= step;
  end

  // Output register: publish the sample one edge after acceptance; reseed flushes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      dither_out <= '0;
    end else if (reseed) begin
      out_valid  <= 1'b0;
    end else if (acc_q) begin
      out_valid  <= 1'b1;
      dither_out <= diff;
    end else begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dither_gen_tpdf.sv
// Bench for dither_gen_tpdf with default parameters: a directed vector table,
// a long back-to-back run against a reference model, lockup repair and
// asynchronous reset sequences.
module tb_dither_gen_tpdf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        req = 1'b0;
  logic        reseed = 1'b0;
  logic [31:0] seed_in = '0;
  logic        out_valid;
  logic [15:0] dither_out;
  logic        lockup_err;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];

  dither_gen_tpdf dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .reseed     (reseed),
    .seed_in    (seed_in),
    .out_valid  (out_valid),
    .dither_out (dither_out),
    .lockup_err (lockup_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        req;
    logic        reseed;
    logic [31:0] seed;
    logic        exp_valid;
    logic [15:0] exp_dout;
    logic [31:0] exp_a0;
    logic [31:0] exp_b0;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference LFSR step for the default mask.
  function automatic logic [31:0] model_step(input logic [31:0] s);
    if (s[0]) return ((s >> 1) ^ 32'h46000000) | 32'h80000000;
    else      return s >> 1;
  endfunction

  function automatic logic [7:0] model_lane(input logic [31:0] a, input logic [31:0] b);
    int d;
    logic [31:0] dv;
    d  = int'(a[6:0]) - int'(b[6:0]);
    dv = d;
    return dv[7:0];
  endfunction

  task automatic drive(input logic e, input logic r, input logic rs, input logic [31:0] s);
    en = e; req = r; reseed = rs; seed_in = s;
  endtask

  task automatic fill_vectors();
    //               en  req rsd seed          vld dout     a0            b0
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'h0000, 32'hB0816454, 32'hC99D2E3B};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 16'hB219, 32'hB0816454, 32'hC99D2E3B};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 16'hB219, 32'hB0816454, 32'hC99D2E3B};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 16'hB219, 32'hB0816454, 32'hC99D2E3B};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 16'hB219, 32'hB0816454, 32'hC99D2E3B};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'hB219, 32'h5840B22A, 32'hA2CE971D};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 16'h190D, 32'h2C205915, 32'h97674B8E};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 16'h0D07, 32'h2C205915, 32'h97674B8E};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 16'h0D07, 32'h2C205915, 32'h97674B8E};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 16'h0D07, 32'hED02C8A9, 32'hFFFFFFFF};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 16'h0D07, 32'hED02C8A9, 32'hFFFFFFFF};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 16'h0D07, 32'hFFFFFFFF, 32'h1F3A5C77};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'h0D07, 32'hB9FFFFFF, 32'hC99D2E3B};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0, 16'h0D07, 32'h12345678, 32'hEDCBA987};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 16'h0D07, 32'h12345678, 32'hEDCBA987};
  endtask

  initial begin
    logic [31:0] ma[2];
    logic [31:0] mb[2];
    logic [31:0] saved_a0;
    logic [15:0] exp_d;
    logic [7:0]  lane;

    fill_vectors();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a0", dut.a_q[0], 32'hED02C8A9);
    check("rst_b0", dut.a_q[0] ^ dut.a_q[0] ^ dut.b_q[0], 32'h1F3A5C77);
    check("rst_a1", dut.a_q[1], 32'hDA059153);
    check("rst_b1", dut.b_q[1], 32'h3E74B8EE);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_dout", 32'(dither_out), 32'h0);
    check("rst_lockup", 32'(lockup_err), 32'h0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].en, vecs[i].req, vecs[i].reseed, vecs[i].seed);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_dout", i), 32'(dither_out), 32'(vecs[i].exp_dout));
      check($sformatf("vec%0d_a0", i), dut.a_q[0], vecs[i].exp_a0);
      check($sformatf("vec%0d_b0", i), dut.b_q[0], vecs[i].exp_b0);
      if (i == 9) begin
        check("reseed0_a1", dut.a_q[1], 32'hDA059153);
        check("reseed0_b1", dut.b_q[1], 32'hFFFFFFFF);
      end
      if (i == 13) begin
        check("reseed_a1", dut.a_q[1], 32'h2468ACF0);
        check("reseed_b1", dut.b_q[1], 32'hDB97530F);
      end
      @(negedge clk);
    end

    // Back-to-back requests for 1000 cycles against the model
    ma[0] = 32'h12345678; mb[0] = 32'hEDCBA987;
    ma[1] = 32'h2468ACF0; mb[1] = 32'hDB97530F;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (i > 0) begin
        exp_d = exp_q.pop_front();
        check("run_valid", 32'(out_valid), 32'h1);
        check("run_dout", 32'(dither_out), 32'(exp_d));
        for (int c = 0; c < 2; c++) begin
          lane = dither_out[c*8 +: 8];
          n_vec++;
          if ($signed(lane) < -127 || $signed(lane) > 127) begin
            n_err++;
            $display("FAIL run_range lane%0d: got %0d, expected within +/-127", c, $signed(lane));
          end
        end
      end
      for (int c = 0; c < 2; c++) begin
        ma[c] = model_step(ma[c]);
        mb[c] = model_step(mb[c]);
      end
      exp_q.push_back({model_lane(ma[1], mb[1]), model_lane(ma[0], mb[0])});
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    exp_d = exp_q.pop_front();
    check("run_last_valid", 32'(out_valid), 32'h1);
    check("run_last_dout", 32'(dither_out), 32'(exp_d));
    check("run_a0", dut.a_q[0], ma[0]);
    check("run_b1", dut.b_q[1], mb[1]);
    @(posedge clk);
    #1;
    check("run_end_valid", 32'(out_valid), 32'h0);
    check("run_lockup_clear", 32'(lockup_err), 32'h0);

    // Lockup repair of A_1, with en low so other LFSRs hold
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    saved_a0 = dut.a_q[0];
    force dut.a_q = {32'h0, saved_a0};
    #1;
    release dut.a_q;
    @(posedge clk);
    #1;
    check("lock_a1", dut.a_q[1], 32'hDA059153);
    check("lock_a0_held", dut.a_q[0], saved_a0);
    check("lock_err", 32'(lockup_err), 32'h1);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("lock_sticky", 32'(lockup_err), 32'h1);
    end
    check("lock_a1_step3", dut.a_q[1], model_step(model_step(model_step(32'hDA059153))));

    // Asynchronous reset between a request and its output edge
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_dout", 32'(dither_out), 32'h0);
    check("arst_lockup", 32'(lockup_err), 32'h0);
    check("arst_a0", dut.a_q[0], 32'hED02C8A9);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("arst_no_pulse", 32'(out_valid), 32'h0);
    end

    // en low freezes LFSRs even with req high
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("en0_a0", dut.a_q[0], 32'hED02C8A9);
    check("en0_b0", dut.b_q[0], 32'h1F3A5C77);
    check("en0_valid", 32'(out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
